// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one von Neumann memory port between two requesters with fair
//   round-robin arbitration. A granted request is latched, the memory access
//   is sequenced (including a fixed read latency), and a one-cycle
//   acknowledge is returned together with the read data.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   ena               global enable; 0 freezes all state
//   req0/addr0/wr_data0/wr_ena0/ack0/rd_data0   requester 0 (CPU)
//   req1/addr1/wr_data1/wr_ena1/ack1/rd_data1   requester 1 (loader/DMA/debug)
//   mem_addr, mem_wr_data, mem_wr_ena           memory request side
//   mem_rd_data                                 memory read data
//
// Handshake: a requester raises reqX with addrX/wr_dataX/wr_enaX and keeps
// req high until it samples ackX=1, then drops req in the following cycle.
// The request is sampled only in IDLE; a req still high in the IDLE cycle
// after DONE starts a new transaction. Dropping req after the grant does not
// cancel the transaction. rd_dataX is valid while ackX=1 and holds until the
// next read of that port completes.

module mem_port_arbiter #(
   parameter int N            = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         req0,
   input  logic [N-1:0] addr0,
   input  logic [N-1:0] wr_data0,
   input  logic         wr_ena0,
   output logic         ack0,
   output logic [N-1:0] rd_data0,
   input  logic         req1,
   input  logic [N-1:0] addr1,
   input  logic [N-1:0] wr_data1,
   input  logic         wr_ena1,
   output logic         ack1,
   output logic [N-1:0] rd_data1,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wr_data,
   output logic         mem_wr_ena,
   input  logic [N-1:0] mem_rd_data
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [2:0] LAT = 3'(READ_LATENCY);

   state_t       state_q, state_d;
   logic         gnt_q;          // port owning the current transaction
   logic         last_grant_q;   // port granted most recently
   logic         we_q;
   logic [N-1:0] addr_q;
   logic [N-1:0] wdata_q;
   logic [2:0]   cnt_q, cnt_d;
   logic [N-1:0] rd_data0_q, rd_data1_q;

   logic         take_grant;
   logic         grant_sel;
   logic         capture;
   logic         wr_strobe;
   logic         ack0_c, ack1_c;

   // Next-state and decode
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      take_grant = 1'b0;
      grant_sel  = 1'b0;
      capture    = 1'b0;
      wr_strobe  = 1'b0;
      ack0_c     = 1'b0;
      ack1_c     = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               take_grant = 1'b1;
               // On a tie the port that was not served last wins.
               if (req0 && req1) grant_sel = ~last_grant_q;
               else              grant_sel = req1;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (we_q) begin
               wr_strobe = 1'b1;
               state_d   = DONE;
            end else begin
               cnt_d   = 3'd1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == LAT) begin
               capture = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         DONE: begin
            ack0_c  = ~gnt_q;
            ack1_c  = gnt_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         gnt_q        <= 1'b0;
         last_grant_q <= 1'b1;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= 3'd0;
         rd_data0_q   <= '0;
         rd_data1_q   <= '0;
      end else if (ena) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (take_grant) begin
            gnt_q        <= grant_sel;
            last_grant_q <= grant_sel;
            we_q         <= grant_sel ? wr_ena1  : wr_ena0;
            addr_q       <= grant_sel ? addr1    : addr0;
            wdata_q      <= grant_sel ? wr_data1 : wr_data0;
         end
         if (capture) begin
            if (gnt_q) rd_data1_q <= mem_rd_data;
            else       rd_data0_q <= mem_rd_data;
         end
      end
   end

   // The latched request registers drive the memory port directly, so the
   // address/data hold their last value in IDLE and DONE.
   assign mem_addr    = addr_q;
   assign mem_wr_data = wdata_q;
   // Strobe is gated by ena so a frozen ACCESS never writes twice.
   assign mem_wr_ena  = wr_strobe & ena;
   // Acks decode from state, so a frozen DONE keeps ack asserted.
   assign ack0        = ack0_c;
   assign ack1        = ack1_c;
   assign rd_data0    = rd_data0_q;
   assign rd_data1    = rd_data1_q;

endmodule
